// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one external multiplier between two requesters.
//
// Purpose
//   Picks a winner among req0/req1, latches its operands into mul_a, mul_b
//   and mul_is_signed, pulses mul_start, waits MUL_LATENCY cycles, then
//   captures mul_s into the owner's result register and pulses its done.
//   State sequence: IDLE -> START (1 cycle) -> WAIT (MUL_LATENCY cycles)
//   -> DONE (1 cycle) -> IDLE.
//
// Configuration
//   MUL_ARB_FIXED_PRIO_EN : when defined, req0 always wins a tie and the
//                           round-robin pointer is not built. When undefined,
//                           a tie goes to the requester not granted last.
//
// Handshake
//   A requester raises req with a/b/is_signed stable and keeps them stable
//   until its one-cycle ack. Requests seen outside IDLE are not queued; a
//   req still high at the next IDLE counts as a new request. done is a
//   one-cycle pulse; result holds until the same requester's next done.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req0/1, a0/1, b0/1           requests and 32-bit operands
//   is_signed0/1                 1 = two's-complement multiply
//   ack0/1, done0/1              one-cycle capture / completion pulses
//   result0/1                    64-bit products, one per requester
//   busy                         high whenever the FSM is not in IDLE
//   mul_start                    one-cycle start strobe to the multiplier
//   mul_a, mul_b, mul_is_signed  latched operands to the multiplier
//   mul_s                        64-bit product from the multiplier
//   dbg_state                    current FSM state (IDLE=0 START=1 WAIT=2 DONE=3)

module mul_arbiter #(
    parameter int MUL_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        is_signed0,
    input  logic        is_signed1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] result0,
    output logic [63:0] result1,
    output logic        busy,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_is_signed,
    input  logic [63:0] mul_s,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(MUL_LATENCY - 1);

    state_t      state, state_n;
    logic        owner, owner_n;
    logic [7:0]  cnt, cnt_n;
    logic        grant;
    logic        ack0_n, ack1_n, done0_n, done1_n, mul_start_n, busy_n;
    logic [31:0] mul_a_n, mul_b_n;
    logic        mul_is_signed_n;
    logic [63:0] result0_n, result1_n;
`ifndef MUL_ARB_FIXED_PRIO_EN
    logic        last, last_n;
`endif

    assign dbg_state = state;

    // Winner of the current IDLE cycle (0 = requester 0, 1 = requester 1).
`ifdef MUL_ARB_FIXED_PRIO_EN
    always_comb grant = ~req0;
`else
    always_comb grant = (req0 & req1) ? ~last : req1;
`endif

    // Next-state and next-output logic. Every output is a flop, so pulses
    // that belong to a state are raised on the transition into that state.
    always_comb begin
        state_n         = state;
        owner_n         = owner;
        cnt_n           = cnt;
        mul_a_n         = mul_a;
        mul_b_n         = mul_b;
        mul_is_signed_n = mul_is_signed;
        result0_n       = result0;
        result1_n       = result1;
        ack0_n          = 1'b0;
        ack1_n          = 1'b0;
        done0_n         = 1'b0;
        done1_n         = 1'b0;
        mul_start_n     = 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
        last_n          = last;
`endif
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_n         = START;
                    owner_n         = grant;
                    mul_a_n         = grant ? a1 : a0;
                    mul_b_n         = grant ? b1 : b0;
                    mul_is_signed_n = grant ? is_signed1 : is_signed0;
                    ack0_n          = ~grant;
                    ack1_n          = grant;
                    mul_start_n     = 1'b1;
`ifndef MUL_ARB_FIXED_PRIO_EN
                    last_n          = grant;
`endif
                end
            end
            START: begin
                cnt_n   = CNT_INIT;
                state_n = WAIT;
            end
            WAIT: begin
                // Counter runs CNT_INIT..0, i.e. MUL_LATENCY cycles in WAIT.
                if (cnt == 8'd0) begin
                    state_n = DONE;
                    if (owner) begin
                        result1_n = mul_s;
                        done1_n   = 1'b1;
                    end else begin
                        result0_n = mul_s;
                        done0_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= 1'b0;
            cnt           <= 8'd0;
            mul_a         <= 32'd0;
            mul_b         <= 32'd0;
            mul_is_signed <= 1'b0;
            result0       <= 64'd0;
            result1       <= 64'd0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            mul_start     <= 1'b0;
            busy          <= 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            last          <= 1'b1;  // requester 0 wins the first tie
`endif
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            cnt           <= cnt_n;
            mul_a         <= mul_a_n;
            mul_b         <= mul_b_n;
            mul_is_signed <= mul_is_signed_n;
            result0       <= result0_n;
            result1       <= result1_n;
            ack0          <= ack0_n;
            ack1          <= ack1_n;
            done0         <= done0_n;
            done1         <= done1_n;
            mul_start     <= mul_start_n;
            busy          <= busy_n;
`ifndef MUL_ARB_FIXED_PRIO_EN
            last          <= last_n;
`endif
        end
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 32, the number of cycles from mul_start to a valid mul_s; legal range 1..255.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock.
REQ-003 rst, input, 1, synchronous active-high reset.
REQ-004 req0 / req1, input, 1 each, request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1, input, 32 each, operands; held stable while req is high until ack.
REQ-006 is_signed0 / is_signed1, input, 1 each, 1 = two's-complement multiply.
REQ-007 ack0 / ack1, output, 1 each, one-cycle pulse when operands are captured.
REQ-008 done0 / done1, output, 1 each, one-cycle pulse when result is valid.
REQ-009 result0 / result1, output, 64 each, product; held until the next done of the same requester.
REQ-010 busy, output, 1, high in every state except IDLE.
REQ-011 mul_start, output, 1, start strobe to the shared multiplier.
REQ-012 mul_a, mul_b, output, 32 each, latched operands to the multiplier.
REQ-013 mul_is_signed, output, 1, latched signedness.
REQ-014 mul_s, input, 64, multiplier product.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT and DONE; all outputs SHALL be registered.
REQ-016 IDLE: if any req is high, the arbiter SHALL latch the winner's a, b and is_signed into mul_a, mul_b and mul_is_signed, record the owner, and go to START; otherwise it stays in IDLE.
REQ-017 START (1 cycle): mul_start=1 and ack of the owner=1; load wait counter with MUL_LATENCY-1; go to WAIT.
REQ-018 WAIT (exactly MUL_LATENCY cycles): counter decrements each cycle; mul_start=0; mul_a, mul_b and mul_is_signed held stable; at counter==0 capture mul_s into the owner's result register and go to DONE.
REQ-019 DONE (1 cycle): the owner's done=1 and its result is valid; go to IDLE.
REQ-020 Latency SHALL be: req sampled in IDLE at cycle 0 -> ack in cycle 1 -> done in cycle MUL_LATENCY+2; back-to-back throughput SHALL be one operation per MUL_LATENCY+3 cycles.
REQ-021 Requests arriving outside IDLE SHALL be ignored until IDLE; they are not queued.
REQ-022 A req that stays high after its ack SHALL be treated as a new request at the next IDLE.
REQ-023 The non-owner's ack, done and result SHALL be unaffected by an operation.
REQ-024 Simultaneous req0 and req1 in IDLE: the requester not granted last SHALL win (round-robin); a single requester SHALL always win.
REQ-025 The last-granted pointer SHALL update on entry to START.
REQ-026 ack and done SHALL never be high for both requesters in the same cycle.

Reset
REQ-027 When rst is high at a clock edge, the arbiter SHALL go to IDLE and clear ack*, done*, mul_start, busy, mul_a, mul_b, mul_is_signed, result0, result1 and the wait counter to 0, and set the last-granted pointer to 1 so requester 0 wins the first tie.
REQ-028 Reset during START, WAIT or DONE SHALL abort the operation with no done pulse; rst SHALL take priority over all other events.

Configuration
REQ-029 Macro MUL_ARB_FIXED_PRIO_EN: when defined, req0 SHALL always win a simultaneous request and the pointer is unused; when undefined, round-robin per REQ-024 applies.

Verification
REQ-030 Unsigned: req0 with a0=b0=3000000000 and is_signed0=0 -> ack0 in cycle 1, done0 in cycle MUL_LATENCY+2, result0=9000000000000000000.
REQ-031 Signed: req1 with a1=0xFFFFFFFD (-3), b1=5, is_signed1=1 -> result1=0xFFFFFFFFFFFFFFF1; result0 unchanged.
REQ-032 Contention: req0 and req1 both held high -> grants alternate 0,1,0,1; with MUL_ARB_FIXED_PRIO_EN, requester 0 is granted every time and requester 1 is never granted.
REQ-033 Late request: req1 asserted during WAIT of a requester-0 operation -> no ack1 until after done0; ack1 arrives exactly 2 cycles after done0.
REQ-034 Reset mid-WAIT: rst asserted one cycle in WAIT -> no done pulse, all outputs 0, busy=0; the next request completes correctly.
REQ-035 Multiplier interface: mul_start is high exactly 1 cycle per operation, and mul_a and mul_b stay stable through WAIT even if a0 and b0 change after ack0.
